// File: rtl/i2s_capture_tdm.sv
// I2S / TDM serial audio capture into a first-word-fall-through FIFO.
// Optional frame-length checking is enabled with macro I2S_CAPTURE_FRAME_CHECK_EN.
module i2s_capture_tdm #(
  parameter int   DATA_W  = 24,
  parameter int   SLOT_W  = 32,
  parameter int   NUM_CH  = 2,
  parameter logic WS_POL  = 1'b0,
  parameter logic LJ_MODE = 1'b0,
  parameter int   DEPTH   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sck_i,
  input  logic                       ws_i,
  input  logic                       sd_i,
  output logic [DATA_W-1:0]          sample_o,
  output logic [$clog2(NUM_CH)-1:0]  ch_o,
  output logic                       last_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic                       frame_err_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int BIT_W = $clog2(SLOT_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = CH_W + DATA_W + 1;

  localparam logic [BIT_W-1:0] FIRST_BIT = BIT_W'(LJ_MODE ? 0 : 1);
  localparam logic [BIT_W:0]   DATA_LEN  = (BIT_W+1)'(DATA_W);
  localparam logic [BIT_W-1:0] LAST_OFF  = BIT_W'(DATA_W-1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_W-1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH-1);

  // Bit [1] is the synchronised level; bit [2] delays it once more for edge detection.
  logic [2:0] sck_sync, ws_sync, sd_sync;
  logic       rise_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      rise_reg <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[1:0], sck_i};
      ws_sync  <= {ws_sync[1:0], ws_i};
      sd_sync  <= {sd_sync[1:0], sd_i};
      rise_reg <= sck_sync[1] & ~sck_sync[2];
    end
  end

  logic              armed, sat, prev_ws;
  logic [CH_W-1:0]   slot, slot_inc, pos_slot;
  logic [BIT_W-1:0]  bit_pos, bit_inc, pos_bit, off;
  logic              frame_start, at_max, live, in_data;
  logic [DATA_W-1:0] shreg;
  logic              push_reg;
  logic [ENT_W-1:0]  push_data;

  assign frame_start = (ws_sync[2] == WS_POL) && (prev_ws != WS_POL);
  assign at_max      = (slot == CH_LAST) && (bit_pos == SLOT_LAST);

  // Position this SCK rise represents, and whether it can carry captured data.
  always_comb begin
    bit_inc  = bit_pos + 1'b1;
    slot_inc = slot;
    if (bit_pos == SLOT_LAST) begin
      bit_inc  = '0;
      slot_inc = slot + 1'b1;
    end
    pos_slot = slot_inc;
    pos_bit  = bit_inc;
    live     = armed;
    if (frame_start) begin
      pos_slot = '0;
      pos_bit  = '0;
      live     = 1'b1;
    end else if (at_max) begin
      pos_slot = slot;
      pos_bit  = bit_pos;
      live     = 1'b0;
    end
    off     = pos_bit - FIRST_BIT;
    in_data = live && ({1'b0, off} < DATA_LEN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed     <= 1'b0;
      sat       <= 1'b0;
      prev_ws   <= WS_POL;
      slot      <= '0;
      bit_pos   <= '0;
      shreg     <= '0;
      push_reg  <= 1'b0;
      push_data <= '0;
    end else begin
      push_reg <= 1'b0;
      if (rise_reg) begin
        prev_ws <= ws_sync[2];
        slot    <= pos_slot;
        bit_pos <= pos_bit;
        sat     <= !frame_start && at_max;
        if (frame_start) armed <= 1'b1;
        if (in_data) begin
          shreg <= {shreg[DATA_W-2:0], sd_sync[2]};
          if (off == LAST_OFF) begin
            push_reg  <= 1'b1;
            push_data <= {pos_slot, shreg[DATA_W-2:0], sd_sync[2], pos_slot == CH_LAST};
          end
        end
      end
    end
  end

`ifdef I2S_CAPTURE_FRAME_CHECK_EN
  logic err_reg;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_reg <= 1'b0;
    else       err_reg <= rise_reg && frame_start && armed && (!at_max || sat);
  end
  assign frame_err_o = err_reg;
`else
  assign frame_err_o = 1'b0;
`endif

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LVL_W-1:0] count, count_next, remain;
  logic [ENT_W-1:0] head;
  logic             ovf, pop, push_ok;

  assign pop        = (count != '0) && ready_i;
  assign push_ok    = push_reg && ((count != LVL_W'(DEPTH)) || pop);
  assign rd_next    = rd_ptr + PTR_W'(pop);
  assign remain     = count - LVL_W'(pop);
  assign count_next = remain + LVL_W'(push_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Head register: refilled from memory, or straight from the push when it lands in an empty FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count_next;
      if (push_reg && !push_ok) ovf <= 1'b1;
      if (remain != '0)  head <= mem[rd_next];
      else if (push_ok)  head <= push_data;
    end
  end

  assign sample_o   = head[DATA_W:1];
  assign ch_o       = head[ENT_W-1 -: CH_W];
  assign last_o     = head[0];
  assign valid_o    = (count != '0);
  assign level_o    = count;
  assign overflow_o = ovf;

endmodule

// File: tb/tb_i2s_capture_tdm.sv
// Scoreboard bench: stereo I2S instance with defaults plus a 4-slot left-justified TDM instance.
module tb_i2s_capture_tdm;

  localparam int DEPTH = 8;
`ifdef I2S_CAPTURE_FRAME_CHECK_EN
  localparam int EXP_ERR = 2;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sck = 1'b0, ws = 1'b1, sd = 1'b0, ready = 1'b0;
  logic [23:0] sample;
  logic        ch, last, valid, ovf, ferr;
  logic [3:0]  level;

  logic        sck2 = 1'b0, ws2 = 1'b1, sd2 = 1'b0, ready2 = 1'b1;
  logic [23:0] sample2;
  logic [1:0]  ch2;
  logic        last2, valid2, ovf2, ferr2;
  logic [3:0]  level2;

  i2s_capture_tdm dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .sample_o(sample), .ch_o(ch), .last_o(last), .valid_o(valid), .ready_i(ready),
    .level_o(level), .overflow_o(ovf), .frame_err_o(ferr)
  );

  i2s_capture_tdm #(.NUM_CH(4), .LJ_MODE(1'b1)) dut_tdm (
    .clk_i(clk), .rst_i(rst), .sck_i(sck2), .ws_i(ws2), .sd_i(sd2),
    .sample_o(sample2), .ch_o(ch2), .last_o(last2), .valid_o(valid2), .ready_i(ready2),
    .level_o(level2), .overflow_o(ovf2), .frame_err_o(ferr2)
  );

  typedef struct packed {
    logic [2:0]  ch;
    logic [23:0] s;
    logic        last;
  } ent_t;

  ent_t        exp_a[$];
  ent_t        exp_b[$];
  int          n_cmp = 0, n_fail = 0;
  int          ferr_a = 0, ferr_b = 0;
  logic        exp_ovf = 1'b0;
  bit          hold = 1'b0, pop_on_push = 1'b0, rnd_ready = 1'b0;
  logic [23:0] smp [8];
  logic [23:0] first_l;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_a
    ent_t e;
    if (ferr) ferr_a++;
    if (!rst && valid && ready) begin
      if (exp_a.size() == 0) check("a_unexpected_entry", {8'h0, sample}, 32'hFFFF_FFFF);
      else begin
        e = exp_a.pop_front();
        $display("pop A ch=%0d sample=%h last=%0d", ch, sample, last);
        check("a_sample", {8'h0, sample}, {8'h0, e.s});
        check("a_ch", {31'h0, ch}, {29'h0, e.ch});
        check("a_last", {31'h0, last}, {31'h0, e.last});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    ent_t e;
    if (ferr2) ferr_b++;
    if (!rst && valid2 && ready2) begin
      if (exp_b.size() == 0) check("b_unexpected_entry", {8'h0, sample2}, 32'hFFFF_FFFF);
      else begin
        e = exp_b.pop_front();
        $display("pop B ch=%0d sample=%h last=%0d", ch2, sample2, last2);
        check("b_sample", {8'h0, sample2}, {8'h0, e.s});
        check("b_ch", {30'h0, ch2}, {29'h0, e.ch});
        check("b_last", {31'h0, last2}, {31'h0, e.last});
      end
    end
  end

  initial begin : rnd_drv
    forever begin
      tick();
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_level", {28'h0, level}, 32'h0);
    check("rst_sample", {8'h0, sample}, 32'h0);
    check("rst_ch_last", {30'h0, ch, last}, 32'h0);
    check("rst_overflow", {31'h0, ovf}, 32'h0);
    check("rst_valid_b", {31'h0, valid2}, 32'h0);
    exp_a.delete();
    exp_b.delete();
    exp_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic sck_bit(input int m, input logic w, input logic d, input logic pulse);
    if (m == 0) begin sck = 1'b0; ws = w; sd = d; end
    else        begin sck2 = 1'b0; ws2 = w; sd2 = d; end
    tick();
    if (m == 0 && pop_on_push) ready = 1'b0;
    repeat (3) tick();
    if (m == 0) sck = 1'b1; else sck2 = 1'b1;
    repeat (4) tick();
    if (pulse) ready = 1'b1;
  endtask

  task automatic push_model(input int m, input int c, input int nch);
    ent_t e;
    e.ch   = 3'(c);
    e.s    = smp[c];
    e.last = (c == nch - 1);
    if (m == 0) begin
      if (hold && exp_a.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_a.push_back(e);
    end else exp_b.push_back(e);
  endtask

  // Frame positions p: slot c = p/32, data bit k = p%32 - delay, MSB first.
  task automatic send_frame(input int m, input int start_p, input int len, input int rst_at, input bit en);
    int   nch, dd, c, k;
    logic w, b;
    bit   live, is_data;
    nch  = (m == 0) ? 2 : 4;
    dd   = (m == 0) ? 1 : 0;
    live = en;
    for (int p = start_p; p < len; p++) begin
      if (p == rst_at) begin
        check("pre_rst_level", {28'h0, level}, exp_a.size());
        do_reset();
        live = 1'b0;
      end
      c = p / 32;
      k = (p % 32) - dd;
      if (m == 0) w = (p < 32) ? 1'b0 : 1'b1;
      else        w = (p == 0) ? 1'b0 : 1'b1;
      is_data = (c < nch) && (k >= 0) && (k < 24);
      b = is_data ? smp[c][23-k] : 1'($urandom_range(0, 1));
      if (is_data && k == 23 && live) push_model(m, c, nch);
      sck_bit(m, w, b, is_data && k == 23 && pop_on_push && m == 0);
    end
  endtask

  task automatic rand_smp();
    for (int i = 0; i < 8; i++) smp[i] = 24'($urandom);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || valid || valid2) && t < 3000) begin
      tick();
      t++;
    end
    check("drain_in_time", {31'h0, t < 3000}, 32'h1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    do_reset();
    check("rst_frame_err", {30'h0, ferr, ferr2}, 32'h0);
    tick();

    // Stereo defaults: partial frame discarded, then fixed and random frames.
    ready = 1'b1;
    send_frame(0, 40, 64, -1, 1'b0);
    smp[0] = 24'hA5A5A5;
    smp[1] = 24'h5A5A5A;
    repeat (3) send_frame(0, 0, 64, -1, 1'b1);
    rnd_ready = 1'b1;
    repeat (4) begin rand_smp(); send_frame(0, 0, 64, -1, 1'b1); end
    rand_smp(); send_frame(0, 0, 80, -1, 1'b1);
    rand_smp(); send_frame(0, 0, 60, -1, 1'b1);
    rand_smp(); send_frame(0, 0, 64, -1, 1'b1);
    rnd_ready = 1'b0;
    ready = 1'b1;
    wait_drain();
    check("a_empty_level", {28'h0, level}, 32'h0);

    // Left-justified 4-slot TDM with a WS pulse.
    send_frame(1, 40, 128, -1, 1'b0);
    smp[0] = 24'h123456; smp[1] = 24'h789ABC; smp[2] = 24'hDEF012; smp[3] = 24'h345678;
    send_frame(1, 0, 128, -1, 1'b1);
    repeat (2) begin rand_smp(); send_frame(1, 0, 128, -1, 1'b1); end
    wait_drain();

    // Consumer stalled for five frames: overflow, oldest eight kept.
    ready = 1'b0;
    hold = 1'b1;
    rand_smp();
    first_l = smp[0];
    send_frame(0, 0, 64, -1, 1'b1);
    repeat (4) begin rand_smp(); send_frame(0, 0, 64, -1, 1'b1); end
    repeat (20) tick();
    check("ovf_level", {28'h0, level}, DEPTH);
    check("ovf_flag", {31'h0, ovf}, {31'h0, exp_ovf});
    check("ovf_head_sample", {8'h0, sample}, {8'h0, first_l});
    check("ovf_head_ch", {31'h0, ch}, 32'h0);
    hold = 1'b0;
    ready = 1'b1;
    wait_drain();
    check("ovf_drained_valid", {31'h0, valid}, 32'h0);
    check("ovf_sticky", {31'h0, ovf}, 32'h1);

    // Full FIFO with push and pop on the same edge.
    do_reset();
    ready = 1'b0;
    hold = 1'b1;
    send_frame(0, 40, 64, -1, 1'b0);
    repeat (4) begin rand_smp(); send_frame(0, 0, 64, -1, 1'b1); end
    repeat (20) tick();
    check("full_level", {28'h0, level}, DEPTH);
    check("full_ovf", {31'h0, ovf}, 32'h0);
    hold = 1'b0;
    pop_on_push = 1'b1;
    rand_smp(); send_frame(0, 0, 64, -1, 1'b1);
    pop_on_push = 1'b0;
    ready = 1'b0;
    repeat (20) tick();
    check("pushpop_level", {28'h0, level}, DEPTH);
    check("pushpop_ovf", {31'h0, ovf}, 32'h0);
    ready = 1'b1;
    wait_drain();

    // Reset in the right slot with three entries queued.
    ready = 1'b0;
    send_frame(0, 40, 64, -1, 1'b0);
    rand_smp(); send_frame(0, 0, 64, -1, 1'b1);
    rand_smp(); send_frame(0, 0, 64, 40, 1'b1);
    ready = 1'b1;
    rand_smp(); send_frame(0, 0, 64, -1, 1'b1);
    wait_drain();

    check("frame_err_a_pulses", ferr_a, EXP_ERR);
    check("frame_err_b_pulses", ferr_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
